sparse_chunk_encoder: RTL and testbench
=======================================

Name: sparse_chunk_encoder

Overview:
- Producer side of the sparse chunk write interface.
- Accepts one dense chunk of MEM_SIZE bytes as MEM_SIZE/BUS_SIZE input beats. Builds the per-byte sparsemap and compacts the nonzero bytes into one contiguous packed stream.
- Replays the chunk as MEM_SIZE/BUS_SIZE write beats (sparsemap slice + packed-data slice) into the chunk memory's write port.
- Sits between the activation/weight producer and the chunk memory.

Parameters:
- MEM_SIZE, 128, chunk size in bytes.
- BUS_SIZE, 16, bytes per beat on both the input and output sides; MEM_SIZE must be a multiple of BUS_SIZE.
- BEAT_NUM, MEM_SIZE/BUS_SIZE (derived localparam), beats per chunk; must be a power of 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_dense_data_i  in  BUS_SIZE×8  dense input beat; lane j is byte j.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  encoder can accept an input beat.
- abort_i  in  1  synchronous discard of the current chunk.
- wr_sparsemap_o  out  BUS_SIZE  sparsemap slice; bit j = 1 iff dense byte j of that beat ≠ 0.
- wr_nonzero_data_o  out  BUS_SIZE×8  packed nonzero bytes for this beat.
- wr_valid_o  out  1  output beat valid.
- wr_ready_i  in  1  downstream accepts the output beat.
- nz_count_o  out  $clog2(MEM_SIZE)+1  number of nonzero bytes in the current chunk.

Behaviour:
- Async reset (rst_ni=0):
  - state=FILL; beat counter=0; packed pointer=0; sparsemap and packed buffers all zero.
  - in_ready_o=1, wr_valid_o=0, nz_count_o=0.
  - Outputs change immediately on reset assertion, including mid-drain.
- Handshakes:
  - in_fire = in_valid_i & in_ready_o.
  - wr_fire = wr_valid_o & wr_ready_i.
  - in_ready_o = (state==FILL). wr_valid_o = (state==DRAIN).
- FILL, on each in_fire:
  - Lane mask m[j] = (byte j ≠ 0). Per-lane exclusive prefix p[j] = popcount(m[j-1:0]), combinational across BUS_SIZE lanes.
  - Store m into the sparsemap buffer slice [beat*BUS_SIZE +: BUS_SIZE].
  - Write each nonzero byte j to packed[ptr + p[j]].
  - ptr += popcount(m); beat++.
  - ptr never exceeds MEM_SIZE; width is $clog2(MEM_SIZE)+1.
- FILL→DRAIN: on the in_fire of beat BEAT_NUM-1.
  - wr_valid_o=1 in the next cycle, so input-to-output latency is 1 cycle after the last input beat.
  - nz_count_o = final ptr, held through DRAIN.
  - Beat counter resets to 0.
- DRAIN, output beat i:
  - wr_sparsemap_o = sparsemap[i*BUS_SIZE +: BUS_SIZE].
  - wr_nonzero_data_o lane j = packed[i*BUS_SIZE+j].
  - Packed positions ≥ nz_count are 0.
  - Packed byte k corresponds to consumer data address k+1, i.e. the inclusive prefix-sum address.
  - Outputs are driven from registers through the beat-counter mux and stay stable while wr_valid_o & !wr_ready_i.
  - wr_fire advances the beat.
- DRAIN→FILL: on the wr_fire of beat BEAT_NUM-1.
  - The same edge clears the packed buffer, sparsemap buffer, ptr and beat counter. nz_count_o clears to 0.
  - in_ready_o=1 the next cycle, so back-to-back chunks have a 1-cycle bubble on each side. No residual bytes leak into the next chunk.
- abort_i=1:
  - Next state = FILL and all buffers, counters and nz_count are cleared, regardless of state.
  - abort_i wins over a simultaneous in_fire or wr_fire; that beat is dropped.
  - abort in FILL with no beats received is a no-op.
- in_valid_i in DRAIN, and wr_ready_i in FILL, are ignored.

Decomposition:
- Package sparse_chunk_pkg holds:
  - localparams for the defaults MEM_SIZE/BUS_SIZE;
  - typedef beat_bytes_t (BUS_SIZE×8);
  - typedef state_e {FILL, DRAIN};
  - function popcount.
- One sub-module, sparse_beat_compactor (combinational):
  - inputs: dense beat;
  - outputs: mask, per-lane prefix, and popcount.
  - Instantiated once, used in FILL.

Test Plan (defaults 128/16, BEAT_NUM=8):
- All-zero chunk, 8 beats → 8 output beats, sparsemap 16'h0000, data all 0, nz_count_o=0, wr_valid_o rises 1 cycle after the 8th in_fire.
- Every byte = index+1 (1..128) → each sparsemap 16'hFFFF, output beat i lane j = 16i+j+1, nz_count_o=128.
- Beat0 lane3=8'hAA, beat5 lane15=8'hBB, rest 0 → sparsemaps: beat0 16'h0008, beat5 16'h8000, others 0; output beat0 lane0=AA, lane1=BB, all other bytes 0; nz_count_o=2.
- Random chunk with wr_ready_i held low 3 cycles on output beat 2 → outputs stable during the stall, exactly 8 beats transferred, matching the reference-model compaction.
- abort_i after 4 input beats, then a full 8-beat chunk with 1 nonzero byte 8'h5C → nz_count_o=1, beat0 lane0=5C, no stale data. Separately, rst_ni low mid-DRAIN → wr_valid_o=0 and in_ready_o=1 immediately.
- Chunk A (128 nonzero) followed immediately by chunk B (3 nonzero) → chunk B's first in_fire is accepted the cycle after A's last wr_fire; B's packed lanes 3..15 of beat0 and all later beats are 0.

Source files
------------

// File: rtl/sparse_chunk_encoder_pkg.sv
// Shared types, default geometry and a popcount helper for the sparse chunk encoder.
package sparse_chunk_pkg;

  localparam int MEM_SIZE_DEF = 128;
  localparam int BUS_SIZE_DEF = 16;

  typedef logic [BUS_SIZE_DEF*8-1:0] beat_bytes_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Caller zero-extends narrower masks; 64 lanes covers any sane bus width.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sparse_chunk_encoder_if.sv
// Input beat handshake plus the chunk-memory write port of the sparse chunk encoder.
interface sparse_chunk_encoder_if
  import sparse_chunk_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int BUS_SIZE = BUS_SIZE_DEF
);

  localparam int NZW = $clog2(MEM_SIZE) + 1;

  logic [BUS_SIZE*8-1:0] in_dense_data_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  abort_i;
  logic [BUS_SIZE-1:0]   wr_sparsemap_o;
  logic [BUS_SIZE*8-1:0] wr_nonzero_data_o;
  logic                  wr_valid_o;
  logic                  wr_ready_i;
  logic [NZW-1:0]        nz_count_o;

  // master = environment (producer + chunk memory), slave = the encoder itself.
  modport master (
    output in_dense_data_i, in_valid_i, abort_i, wr_ready_i,
    input  in_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o, nz_count_o
  );

  modport slave (
    input  in_dense_data_i, in_valid_i, abort_i, wr_ready_i,
    output in_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o, nz_count_o
  );

endinterface

// File: rtl/sparse_chunk_encoder_compactor.sv
// Per-beat nonzero lane mask, exclusive prefix count per lane and total nonzero count.
module sparse_beat_compactor
  import sparse_chunk_pkg::*;
#(
  parameter  int BUS_SIZE = BUS_SIZE_DEF,
  localparam int CW       = $clog2(BUS_SIZE) + 1
) (
  input  logic [BUS_SIZE*8-1:0]         dense_i,
  output logic [BUS_SIZE-1:0]           mask_o,
  output logic [BUS_SIZE-1:0][CW-1:0]   prefix_o,
  output logic [CW-1:0]                 count_o
);

  // Ripple prefix: lane j lands at offset = number of nonzero lanes below it.
  always_comb begin
    logic [CW-1:0] runSum;
    logic [63:0]   maskWide;
    mask_o   = '0;
    prefix_o = '0;
    runSum   = '0;
    for (int j = 0; j < BUS_SIZE; j++) begin
      mask_o[j]   = |dense_i[j*8 +: 8];
      prefix_o[j] = runSum;
      runSum      = runSum + CW'(mask_o[j]);
    end
    maskWide                 = '0;
    maskWide[BUS_SIZE-1:0]   = mask_o;
    count_o                  = CW'(popcount(maskWide));
  end

endmodule

// File: rtl/sparse_chunk_encoder.sv
// Collects a dense chunk, compacts its nonzero bytes into a packed buffer with a
// per-byte sparsemap, then replays both to the chunk memory beat by beat.
module sparse_chunk_encoder
  import sparse_chunk_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int BUS_SIZE = BUS_SIZE_DEF
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  sparse_chunk_encoder_if.slave bus
);

  localparam int BEAT_NUM = MEM_SIZE / BUS_SIZE;
  localparam int BW       = $clog2(BEAT_NUM);
  localparam int BSW      = $clog2(BUS_SIZE);
  localparam int AW       = BW + BSW;
  localparam int PTRW     = $clog2(MEM_SIZE) + 1;
  localparam int CW       = $clog2(BUS_SIZE) + 1;

  state_e                                 state_q, state_d;
  logic [BW-1:0]                          beatCnt_q, beatCnt_d;
  logic [PTRW-1:0]                        ptr_q, ptr_d;
  logic [BEAT_NUM-1:0][BUS_SIZE-1:0]      sparseMap_q, sparseMap_d;
  logic [BEAT_NUM-1:0][BUS_SIZE-1:0][7:0] packedBuf_q, packedBuf_d;

  logic [BUS_SIZE-1:0]         laneMask;
  logic [BUS_SIZE-1:0][CW-1:0] lanePrefix;
  logic [CW-1:0]               laneCount;

  sparse_beat_compactor #(.BUS_SIZE(BUS_SIZE)) compactor (
    .dense_i  (bus.in_dense_data_i),
    .mask_o   (laneMask),
    .prefix_o (lanePrefix),
    .count_o  (laneCount)
  );

  logic lastBeat;
  assign lastBeat = (beatCnt_q == BW'(BEAT_NUM - 1));

  // Abort and end-of-drain share the same full clear so no byte survives into the next chunk.
  always_comb begin
    logic [AW-1:0] slot;
    state_d     = state_q;
    beatCnt_d   = beatCnt_q;
    ptr_d       = ptr_q;
    sparseMap_d = sparseMap_q;
    packedBuf_d = packedBuf_q;
    slot        = '0;
    if (bus.abort_i) begin
      state_d     = FILL;
      beatCnt_d   = '0;
      ptr_d       = '0;
      sparseMap_d = '0;
      packedBuf_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.in_valid_i) begin
            sparseMap_d[beatCnt_q] = laneMask;
            for (int j = 0; j < BUS_SIZE; j++) begin
              if (laneMask[j]) begin
                slot = AW'(ptr_q + PTRW'(lanePrefix[j]));
                packedBuf_d[slot[AW-1:BSW]][slot[BSW-1:0]] = bus.in_dense_data_i[j*8 +: 8];
              end
            end
            ptr_d = ptr_q + PTRW'(laneCount);
            if (lastBeat) begin
              state_d   = DRAIN;
              beatCnt_d = '0;
            end else begin
              beatCnt_d = beatCnt_q + BW'(1);
            end
          end
        end
        DRAIN: begin
          if (bus.wr_ready_i) begin
            if (lastBeat) begin
              state_d     = FILL;
              beatCnt_d   = '0;
              ptr_d       = '0;
              sparseMap_d = '0;
              packedBuf_d = '0;
            end else begin
              beatCnt_d = beatCnt_q + BW'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FILL;
      beatCnt_q   <= '0;
      ptr_q       <= '0;
      sparseMap_q <= '0;
      packedBuf_q <= '0;
    end else begin
      state_q     <= state_d;
      beatCnt_q   <= beatCnt_d;
      ptr_q       <= ptr_d;
      sparseMap_q <= sparseMap_d;
      packedBuf_q <= packedBuf_d;
    end
  end

  assign bus.in_ready_o        = (state_q == FILL);
  assign bus.wr_valid_o        = (state_q == DRAIN);
  assign bus.wr_sparsemap_o    = sparseMap_q[beatCnt_q];
  assign bus.wr_nonzero_data_o = packedBuf_q[beatCnt_q];
  assign bus.nz_count_o        = ptr_q;

endmodule

// File: tb/tb_sparse_chunk_encoder.sv
// Directed bench for sparse_chunk_encoder: chunks are compacted by a sequential
// reference model and every drained beat is compared against it.
module tb_sparse_chunk_encoder;
  import sparse_chunk_pkg::*;

  localparam int MEM   = 128;
  localparam int BUS   = 16;
  localparam int BEATS = MEM / BUS;

  logic clk  = 1'b0;
  logic rstN = 1'b1;

  always #5 clk = ~clk;

  sparse_chunk_encoder_if #(.MEM_SIZE(MEM), .BUS_SIZE(BUS)) bus ();

  sparse_chunk_encoder #(.MEM_SIZE(MEM), .BUS_SIZE(BUS)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  chunk   [MEM];
  logic [15:0] expMap  [BEATS];
  beat_bytes_t expData [BEATS];
  int          expNz;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sequential compaction: walk bytes in address order, append each nonzero one.
  task automatic buildModel();
    int cnt;
    cnt = 0;
    for (int i = 0; i < BEATS; i++) begin
      expMap[i]  = '0;
      expData[i] = '0;
    end
    for (int k = 0; k < MEM; k++) begin
      if (chunk[k] != 8'h00) begin
        expMap[k / BUS][k % BUS]           = 1'b1;
        expData[cnt / BUS][(cnt % BUS)*8 +: 8] = chunk[k];
        cnt++;
      end
    end
    expNz = cnt;
  endtask

  task automatic clearChunk();
    for (int k = 0; k < MEM; k++) chunk[k] = 8'h00;
  endtask

  task automatic applyStimulus(input int handNz);
    beat_bytes_t beat;
    int          wantNz;
    buildModel();
    wantNz = (handNz < 0) ? expNz : handNz;
    for (int b = 0; b < BEATS; b++) begin
      for (int j = 0; j < BUS; j++) beat[j*8 +: 8] = chunk[b*BUS + j];
      bus.in_dense_data_i = beat;
      bus.in_valid_i      = 1'b1;
      checkOutput($sformatf("in_ready_b%0d", b), 128'(bus.in_ready_o), 128'd1);
      checkOutput($sformatf("early_valid_b%0d", b), 128'(bus.wr_valid_o), 128'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid_i      = 1'b0;
    bus.in_dense_data_i = '0;
    checkOutput("latency_valid", 128'(bus.wr_valid_o), 128'd1);
    checkOutput("drain_ready", 128'(bus.in_ready_o), 128'd0);
    checkOutput("nz_count", 128'(bus.nz_count_o), 128'(wantNz));
  endtask

  task automatic drainChunk(input int stallBeat, input int stallCycles);
    bus.wr_ready_i = 1'b1;
    for (int i = 0; i < BEATS; i++) begin
      if (i == stallBeat) begin
        bus.wr_ready_i = 1'b0;
        repeat (stallCycles) begin
          @(posedge clk);
          #1;
          checkOutput("stall_valid", 128'(bus.wr_valid_o), 128'd1);
          checkOutput("stall_map", 128'(bus.wr_sparsemap_o), 128'(expMap[i]));
          checkOutput("stall_data", bus.wr_nonzero_data_o, expData[i]);
        end
        bus.wr_ready_i = 1'b1;
      end
      checkOutput($sformatf("valid_b%0d", i), 128'(bus.wr_valid_o), 128'd1);
      checkOutput($sformatf("map_b%0d", i), 128'(bus.wr_sparsemap_o), 128'(expMap[i]));
      checkOutput($sformatf("data_b%0d", i), bus.wr_nonzero_data_o, expData[i]);
      checkOutput($sformatf("nz_b%0d", i), 128'(bus.nz_count_o), 128'(expNz));
      @(posedge clk);
      #1;
    end
    bus.wr_ready_i = 1'b0;
    checkOutput("post_valid", 128'(bus.wr_valid_o), 128'd0);
    checkOutput("post_ready", 128'(bus.in_ready_o), 128'd1);
    checkOutput("post_nz", 128'(bus.nz_count_o), 128'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.in_dense_data_i = '0;
    bus.in_valid_i      = 1'b0;
    bus.abort_i         = 1'b0;
    bus.wr_ready_i      = 1'b0;

    #1 rstN = 1'b0;
    #10;
    checkOutput("rst_ready", 128'(bus.in_ready_o), 128'd1);
    checkOutput("rst_valid", 128'(bus.wr_valid_o), 128'd0);
    checkOutput("rst_nz", 128'(bus.nz_count_o), 128'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] all-zero chunk");
    clearChunk();
    applyStimulus(0);
    drainChunk(-1, 0);

    $display("[TB] dense chunk 1..128");
    for (int k = 0; k < MEM; k++) chunk[k] = 8'(k + 1);
    applyStimulus(128);
    checkOutput("dense_map0", 128'(bus.wr_sparsemap_o), 128'h0000_FFFF);
    drainChunk(-1, 0);

    $display("[TB] two sparse bytes");
    clearChunk();
    chunk[3]  = 8'hAA;
    chunk[95] = 8'hBB;
    applyStimulus(2);
    checkOutput("two_map0", 128'(bus.wr_sparsemap_o), 128'h0008);
    checkOutput("two_data0", bus.wr_nonzero_data_o, 128'hBBAA);
    drainChunk(-1, 0);

    $display("[TB] random chunk with stall");
    for (int k = 0; k < MEM; k++) begin
      chunk[k] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
    end
    applyStimulus(-1);
    drainChunk(2, 3);

    $display("[TB] abort after four beats");
    for (int b = 0; b < 4; b++) begin
      bus.in_dense_data_i = '1;
      bus.in_valid_i      = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.abort_i = 1'b1;
    @(posedge clk);
    #1;
    bus.abort_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_dense_data_i = '0;
    checkOutput("abort_ready", 128'(bus.in_ready_o), 128'd1);
    checkOutput("abort_valid", 128'(bus.wr_valid_o), 128'd0);
    checkOutput("abort_nz", 128'(bus.nz_count_o), 128'd0);
    bus.abort_i = 1'b1;
    @(posedge clk);
    #1;
    bus.abort_i = 1'b0;
    checkOutput("idle_abort_ready", 128'(bus.in_ready_o), 128'd1);
    clearChunk();
    chunk[70] = 8'h5C;
    applyStimulus(1);
    checkOutput("abort_map4_via_data0", bus.wr_nonzero_data_o, 128'h5C);
    drainChunk(-1, 0);

    $display("[TB] reset during drain");
    for (int k = 0; k < MEM; k++) chunk[k] = 8'(k + 1);
    applyStimulus(128);
    bus.wr_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.wr_ready_i = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_valid", 128'(bus.wr_valid_o), 128'd0);
    checkOutput("midrst_ready", 128'(bus.in_ready_o), 128'd1);
    checkOutput("midrst_nz", 128'(bus.nz_count_o), 128'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back chunks");
    for (int k = 0; k < MEM; k++) chunk[k] = 8'(255 - k);
    applyStimulus(128);
    drainChunk(-1, 0);
    clearChunk();
    chunk[5]   = 8'h11;
    chunk[40]  = 8'h22;
    chunk[127] = 8'h33;
    applyStimulus(3);
    checkOutput("b2b_data0", bus.wr_nonzero_data_o, 128'h33_2211);
    drainChunk(-1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
